counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer_if.sv | 26 ++
 rtl/counter_sequencer.sv | 89 ++++++++
 tb/tb_counter_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Command/status bundle for counter_sequencer.
// The master side issues commands; the slave side is the sequencer itself.
interface counter_sequencer_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             dir;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] count;
    logic [1:0]       state;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, pause, dir, load_val, term_val,
        input  count, state, busy, done
    );

    modport slave (
        input  start, stop, pause, dir, load_val, term_val,
        output count, state, busy, done
    );
endinterface

// File: rtl/counter_sequencer.sv
// Loadable up/down counter that runs from load_val until it reaches term_val.
// It supports pause/hold and stop/abort, and gives a one-cycle done pulse.
module counter_sequencer #(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        // NOTE: assign every output a default first, so that no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = RUN;
                    count_d = bus.load_val;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.pause) begin
                    state_d = HOLD;
                end else if (count_q == bus.term_val) begin
                    state_d = DONE;
                end else if (bus.dir) begin
                    count_d = count_q + 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            HOLD: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (!bus.pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy and done come from their own flops, so the output pins see no decode glitches.
    always_comb begin
        busy_d = (state_d == RUN) || (state_d == HOLD);
        done_d = (state_d == DONE);
    end

    // NOTE: use non-blocking assignments for the state flops, so that every register samples values from before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.state = state_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer.
// The bench drives inputs and samples outputs on the falling clock edge.
module tb_counter_sequencer;

    localparam int         W = 3;
    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] H = 2'b10;
    localparam logic [1:0] D = 2'b11;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    counter_sequencer_if #(.WIDTH(W)) bus ();

    counter_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs the observed outputs as {count, state, busy, done}.
    function automatic logic [6:0] obs();
        return {bus.count, bus.state, bus.busy, bus.done};
    endfunction

    // Expected packed outputs: busy is high in RUN/HOLD, and done is high in DONE.
    function automatic logic [6:0] pk(input int c, input logic [1:0] s);
        logic [W-1:0] cv;
        cv = W'(c);
        return {cv, s, (s == R) || (s == H), (s == D)};
    endfunction

    task automatic test_reset();
        logic [6:0] e;
        reset = 1'b0;
        bus.start = 1'b1; bus.stop = 1'b0; bus.pause = 1'b0; bus.dir = 1'b1;
        bus.load_val = 3'd5; bus.term_val = 3'd7;
        e = pk(0, I);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL reset_hold cyc %0d: got %b want %b", i, obs(), e);
            end
        end
        bus.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL reset_release: got %b want %b", obs(), e);
        end
    endtask

    task automatic test_up_run();
        logic [6:0] e [6];
        e = '{pk(2, R), pk(3, R), pk(4, R), pk(5, R), pk(5, D), pk(5, I)};
        bus.load_val = 3'd2; bus.term_val = 3'd5; bus.dir = 1'b1; bus.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            tests++;
            if (obs() !== e[i]) begin
                fails++;
                $display("FAIL up_run step %0d: got %b want %b", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_down_wrap();
        logic [6:0] e [6];
        e = '{pk(1, R), pk(0, R), pk(7, R), pk(6, R), pk(6, D), pk(6, I)};
        bus.load_val = 3'd1; bus.term_val = 3'd6; bus.dir = 1'b0; bus.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            tests++;
            if (obs() !== e[i]) begin
                fails++;
                $display("FAIL down_wrap step %0d: got %b want %b", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [6:0] e [6];
        e = '{pk(6, R), pk(7, R), pk(0, R), pk(1, R), pk(1, D), pk(1, I)};
        bus.load_val = 3'd6; bus.term_val = 3'd1; bus.dir = 1'b1; bus.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            tests++;
            if (obs() !== e[i]) begin
                fails++;
                $display("FAIL up_wrap step %0d: got %b want %b", i, obs(), e[i]);
            end
        end
    endtask

    // This task leaves the block in RUN at count 4 for test_priority.
    task automatic test_pause();
        logic [6:0] e [9];
        logic       p [9];
        e = '{pk(0, R), pk(1, R), pk(2, R), pk(3, R), pk(3, H), pk(3, H), pk(3, H),
              pk(3, R), pk(4, R)};
        p = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        bus.load_val = 3'd0; bus.term_val = 3'd7; bus.dir = 1'b1; bus.start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            tests++;
            if (obs() !== e[i]) begin
                fails++;
                $display("FAIL pause step %0d: got %b want %b", i, obs(), e[i]);
            end
            bus.pause = p[i];
        end
    endtask

    task automatic test_priority();
        logic [6:0] e [6];
        e = '{pk(4, I), pk(4, I), pk(5, R), pk(5, D), pk(5, I), pk(5, I)};
        // Step 0: stop together with pause in RUN. Step 1: start together with stop in IDLE.
        // Steps 2-5: load_val equal to term_val, with a start presented during DONE.
        bus.stop = 1'b1; bus.pause = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (obs() !== e[i]) begin
                fails++;
                $display("FAIL priority step %0d: got %b want %b", i, obs(), e[i]);
            end
            bus.stop = 1'b0; bus.pause = 1'b0; bus.start = 1'b0;
            case (i)
                0: begin bus.start = 1'b1; bus.stop = 1'b1; bus.load_val = 3'd2; end
                1: begin bus.start = 1'b1; bus.load_val = 3'd5; bus.term_val = 3'd5; end
                3: begin bus.start = 1'b1; bus.load_val = 3'd1; end
                default: ;
            endcase
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] e [3];
        logic [6:0] z;
        e = '{pk(4, R), pk(5, R), pk(6, R)};
        z = pk(0, I);
        bus.load_val = 3'd4; bus.term_val = 3'd7; bus.dir = 1'b1; bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            tests++;
            if (obs() !== e[i]) begin
                fails++;
                $display("FAIL async_run step %0d: got %b want %b", i, obs(), e[i]);
            end
        end
        #1 reset = 1'b0;
        #1;
        tests++;
        if (obs() !== z) begin
            fails++;
            $display("FAIL async_assert: got %b want %b", obs(), z);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (obs() !== z) begin
            fails++;
            $display("FAIL async_idle_wait: got %b want %b", obs(), z);
        end
        bus.load_val = 3'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        if (obs() !== pk(3, R)) begin
            fails++;
            $display("FAIL async_restart: got %b want %b", obs(), pk(3, R));
        end
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        tests++;
        if (obs() !== pk(3, I)) begin
            fails++;
            $display("FAIL async_stop: got %b want %b", obs(), pk(3, I));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_up_run();
        test_down_wrap();
        test_up_wrap();
        test_pause();
        test_priority();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
